// File: rtl/a_arbiter_ctrl_pp_if.sv
// Bus-side signal bundle of the serial-bus arbiter.
//   master modport : arbiter view (samples id/com_state/done, drives cmd/bus_state/busy/timeout_err)
//   slave modport  : fabric view (drives requests and master status, samples arbiter outputs)
// Ports carried:
//   id[m]        requested slave per master, 0 = idle
//   com_state[m] 00 END_COM, 01 NAK, 10 WAIT_ACK, 11 COM
//   done[m]      master has released after a STOP command
//   cmd[m]       00 WAIT, 01 STOP_S, 10 STOP_P, 11 CLEAR
//   bus_state    {master, slave} mux select, 0 = bus idle
//   busy         arbiter not idle
//   timeout_err  one-cycle watchdog pulse
interface a_arbiter_ctrl_pp_if #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3
);
    localparam int S_ID_WIDTH = $clog2(NO_SLAVES + 1);
    localparam int M_ID_WIDTH = $clog2(NO_MASTERS);

    logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0]  id;
    logic [NO_MASTERS-1:0][1:0]             com_state;
    logic [NO_MASTERS-1:0]                  done;
    logic [NO_MASTERS-1:0][1:0]             cmd;
    logic [M_ID_WIDTH+S_ID_WIDTH-1:0]       bus_state;
    logic                                   busy;
    logic                                   timeout_err;

    modport master (
        input  id, com_state, done,
        output cmd, bus_state, busy, timeout_err
    );

    modport slave (
        output id, com_state, done,
        input  cmd, bus_state, busy, timeout_err
    );
endinterface

// File: rtl/a_arbiter_ctrl_pp.sv
// Central bus arbiter: grants one master at a time, drives the bus-mux select,
// supports fixed or round-robin selection, one-level preemption with pause/resume
// and ACK/DRAIN watchdogs. All outputs are registered.
// Ports:
//   clk   rising-edge clock
//   rstN  asynchronous active-low reset
//   bus   a_arbiter_ctrl_pp_if.master (id, com_state, done in; cmd, bus_state, busy, timeout_err out)
//
// state  | meaning
// IDLE   | no owner, waiting for a request
// ALLOC  | owner latched, issue CLEAR
// ACK    | waiting for owner COM / NAK, watchdog running
// COM    | bus connected, hold counter running, preemption possible
// DRAIN  | STOP issued, waiting for owner done, watchdog running
// RESUME | transfer over, hand back to a paused master or go idle
module a_arbiter_ctrl_pp #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int THRESH     = 1000,
    parameter int ARB_MODE   = 0,
    parameter int PREEMPT_EN = 1,
    parameter int TIMEOUT    = 64
) (
    input logic                 clk,
    input logic                 rstN,
    a_arbiter_ctrl_pp_if.master bus
);
    localparam int S_ID_WIDTH = $clog2(NO_SLAVES + 1);
    localparam int M_ID_WIDTH = $clog2(NO_MASTERS);
    localparam int HW         = $clog2(THRESH + 1);
    localparam int WW         = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CS_END = 2'b00, CS_NAK = 2'b01, CS_COM = 2'b11;
    localparam logic [1:0] C_WAIT = 2'b00, C_STOP_S = 2'b01, C_STOP_P = 2'b10, C_CLEAR = 2'b11;

    typedef enum logic [2:0] {IDLE, ALLOC, ACK, COM, DRAIN, RESUME} state_t;

    state_t                             state_q, state_d;
    logic [M_ID_WIDTH-1:0]              owner_q, owner_d, chal_q, chal_d, saved_owner_q, saved_owner_d;
    logic [M_ID_WIDTH-1:0]              rr_q, rr_d;
    logic [S_ID_WIDTH-1:0]              slave_q, slave_d, chal_slave_q, chal_slave_d;
    logic [S_ID_WIDTH-1:0]              saved_slave_q, saved_slave_d;
    logic                               saved_valid_q, saved_valid_d, stop_p_q, stop_p_d;
    logic [HW-1:0]                      hold_q, hold_d;
    logic [WW-1:0]                      wd_q, wd_d;
    logic [NO_MASTERS-1:0][1:0]         cmd_q, cmd_d;
    logic [M_ID_WIDTH+S_ID_WIDTH-1:0]   bus_q, bus_d;
    logic                               busy_q, busy_d, tmo_q, tmo_d;

    logic [NO_MASTERS-1:0]              req;
    logic                               fix_valid, rr_valid, sel_valid, below_thr, wd_expired;
    logic [M_ID_WIDTH-1:0]              fix_idx, rr_idx, sel_idx;

    assign bus.cmd         = cmd_q;
    assign bus.bus_state   = bus_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tmo_q;

    assign below_thr  = (hold_q < HW'(THRESH));
    assign wd_expired = (wd_q == WW'(TIMEOUT - 1));

    // Requesters exclude the current owner and a paused master, so neither
    // can win arbitration against itself.
    always_comb begin
        req       = '0;
        fix_valid = 1'b0;
        fix_idx   = '0;
        rr_valid  = 1'b0;
        rr_idx    = '0;
        for (int m = 0; m < NO_MASTERS; m++) begin
            req[m] = (bus.id[m] != '0)
                     && !((state_q != IDLE) && (owner_q == M_ID_WIDTH'(m)))
                     && !(saved_valid_q && (saved_owner_q == M_ID_WIDTH'(m)));
        end
        for (int m = NO_MASTERS - 1; m >= 0; m--) begin
            if (req[m]) begin
                fix_valid = 1'b1;
                fix_idx   = M_ID_WIDTH'(m);
            end
        end
        for (int k = 1; k <= NO_MASTERS; k++) begin
            if (!rr_valid && req[(int'(rr_q) + k) % NO_MASTERS]) begin
                rr_valid = 1'b1;
                rr_idx   = M_ID_WIDTH'((int'(rr_q) + k) % NO_MASTERS);
            end
        end
        sel_valid = (ARB_MODE == 1) ? rr_valid : fix_valid;
        sel_idx   = (ARB_MODE == 1) ? rr_idx   : fix_idx;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            chal_q        <= '0;
            saved_owner_q <= '0;
            rr_q          <= '0;
            slave_q       <= '0;
            chal_slave_q  <= '0;
            saved_slave_q <= '0;
            saved_valid_q <= 1'b0;
            stop_p_q      <= 1'b0;
            hold_q        <= '0;
            wd_q          <= '0;
            cmd_q         <= '0;
            bus_q         <= '0;
            busy_q        <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            chal_q        <= chal_d;
            saved_owner_q <= saved_owner_d;
            rr_q          <= rr_d;
            slave_q       <= slave_d;
            chal_slave_q  <= chal_slave_d;
            saved_slave_q <= saved_slave_d;
            saved_valid_q <= saved_valid_d;
            stop_p_q      <= stop_p_d;
            hold_q        <= hold_d;
            wd_q          <= wd_d;
            cmd_q         <= cmd_d;
            bus_q         <= bus_d;
            busy_q        <= busy_d;
            tmo_q         <= tmo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        chal_d        = chal_q;
        saved_owner_d = saved_owner_q;
        rr_d          = rr_q;
        slave_d       = slave_q;
        chal_slave_d  = chal_slave_q;
        saved_slave_d = saved_slave_q;
        saved_valid_d = saved_valid_q;
        stop_p_d      = stop_p_q;
        hold_d        = hold_q;
        cmd_d         = cmd_q;
        bus_d         = bus_q;
        tmo_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    owner_d = sel_idx;
                    slave_d = bus.id[sel_idx];
                    rr_d    = sel_idx;
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                cmd_d          = '0;
                cmd_d[owner_q] = C_CLEAR;
                state_d        = ACK;
            end
            ACK: begin
                if (bus.com_state[owner_q] == CS_COM) begin
                    bus_d   = {owner_q, slave_q};
                    hold_d  = '0;
                    state_d = COM;
                end else if (bus.com_state[owner_q] == CS_NAK) begin
                    bus_d   = '0;
                    cmd_d   = '0;
                    state_d = RESUME;
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    bus_d   = '0;
                    cmd_d   = '0;
                    state_d = RESUME;
                end
            end
            COM: begin
                if (below_thr) hold_d = hold_q + 1'b1;
                if (bus.com_state[owner_q] == CS_END) begin
                    bus_d   = '0;
                    cmd_d   = '0;
                    state_d = RESUME;
                end else if ((PREEMPT_EN != 0) && !saved_valid_q && fix_valid && (fix_idx < owner_q)) begin
                    // Preemption always follows index order, even in round-robin mode.
                    chal_d         = fix_idx;
                    chal_slave_d   = bus.id[fix_idx];
                    stop_p_d       = below_thr;
                    cmd_d[owner_q] = below_thr ? C_STOP_P : C_STOP_S;
                    state_d        = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.done[owner_q] || wd_expired) begin
                    // A paused owner is remembered only if it released cleanly.
                    if (bus.done[owner_q] && stop_p_q) begin
                        saved_owner_d = owner_q;
                        saved_slave_d = slave_q;
                        saved_valid_d = 1'b1;
                    end
                    tmo_d   = !bus.done[owner_q];
                    bus_d   = '0;
                    cmd_d   = '0;
                    owner_d = chal_q;
                    slave_d = chal_slave_q;
                    state_d = ALLOC;
                end
            end
            RESUME: begin
                cmd_d = '0;
                if (saved_valid_q) begin
                    owner_d       = saved_owner_q;
                    slave_d       = saved_slave_q;
                    saved_valid_d = 1'b0;
                    state_d       = ALLOC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            wd_d = '0;
        else if (state_q == ACK || state_q == DRAIN)
            wd_d = wd_q + 1'b1;
        else
            wd_d = '0;

        busy_d = (state_d != IDLE);
    end
endmodule

// File: tb/tb_a_arbiter_ctrl_pp.sv
// Directed bench for a_arbiter_ctrl_pp. Four arbiters with different parameter
// sets share one stimulus bus; each scenario checks only the instance it targets.
//   u_a : defaults (fixed priority, preemption, THRESH 1000, TIMEOUT 64)
//   u_b : round-robin, no preemption
//   u_c : THRESH 8
//   u_d : TIMEOUT 16
module tb_a_arbiter_ctrl_pp;
    logic clk;
    logic rstN;
    logic [1:0][1:0] id_v;
    logic [1:0][1:0] com_v;
    logic [1:0]      done_v;

    int n_cmp = 0;
    int n_err = 0;

    a_arbiter_ctrl_pp_if #(.NO_MASTERS(2), .NO_SLAVES(3)) if_a ();
    a_arbiter_ctrl_pp_if #(.NO_MASTERS(2), .NO_SLAVES(3)) if_b ();
    a_arbiter_ctrl_pp_if #(.NO_MASTERS(2), .NO_SLAVES(3)) if_c ();
    a_arbiter_ctrl_pp_if #(.NO_MASTERS(2), .NO_SLAVES(3)) if_d ();

    assign if_a.id = id_v;  assign if_a.com_state = com_v;  assign if_a.done = done_v;
    assign if_b.id = id_v;  assign if_b.com_state = com_v;  assign if_b.done = done_v;
    assign if_c.id = id_v;  assign if_c.com_state = com_v;  assign if_c.done = done_v;
    assign if_d.id = id_v;  assign if_d.com_state = com_v;  assign if_d.done = done_v;

    a_arbiter_ctrl_pp #(.NO_MASTERS(2), .NO_SLAVES(3), .THRESH(1000), .ARB_MODE(0),
                        .PREEMPT_EN(1), .TIMEOUT(64))
        u_a (.clk(clk), .rstN(rstN), .bus(if_a));
    a_arbiter_ctrl_pp #(.NO_MASTERS(2), .NO_SLAVES(3), .THRESH(1000), .ARB_MODE(1),
                        .PREEMPT_EN(0), .TIMEOUT(64))
        u_b (.clk(clk), .rstN(rstN), .bus(if_b));
    a_arbiter_ctrl_pp #(.NO_MASTERS(2), .NO_SLAVES(3), .THRESH(8), .ARB_MODE(0),
                        .PREEMPT_EN(1), .TIMEOUT(64))
        u_c (.clk(clk), .rstN(rstN), .bus(if_c));
    a_arbiter_ctrl_pp #(.NO_MASTERS(2), .NO_SLAVES(3), .THRESH(1000), .ARB_MODE(0),
                        .PREEMPT_EN(1), .TIMEOUT(16))
        u_d (.clk(clk), .rstN(rstN), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] END_C = 2'b00, WACK = 2'b10, COM_C = 2'b11;
    localparam logic [1:0] WAIT = 2'b00, STOP_S = 2'b01, STOP_P = 2'b10, CLEAR = 2'b11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        id_v   = '0;
        com_v  = '0;
        done_v = '0;
        rstN   = 1'b0;
        tick(2);
        rstN   = 1'b1;
    endtask

    int order [3] = '{1, 0, 1};

    initial begin
        rstN = 1'b0;
        do_reset();
        chk("rst_bus",  32'(if_a.bus_state), 0);
        chk("rst_cmd",  32'(if_a.cmd), 0);
        chk("rst_busy", 32'(if_a.busy), 0);
        chk("rst_tmo",  32'(if_a.timeout_err), 0);

        // single transfer m1 -> slave 2
        id_v[1] = 2'd2;
        tick(1);
        chk("t1_alloc_busy", 32'(if_a.busy), 1);
        chk("t1_alloc_cmd",  32'(if_a.cmd[1]), WAIT);
        tick(1);
        chk("t1_clear", 32'(if_a.cmd[1]), CLEAR);
        chk("t1_cmd0",  32'(if_a.cmd[0]), WAIT);
        chk("t1_bus_ack", 32'(if_a.bus_state), 0);
        tick(1);
        com_v[1] = COM_C;
        tick(1);
        chk("t1_bus_com", 32'(if_a.bus_state), 3'b110);
        tick(9);
        chk("t1_bus_hold", 32'(if_a.bus_state), 3'b110);
        com_v[1] = END_C;
        id_v[1]  = 2'd0;
        tick(1);
        chk("t1_bus_end", 32'(if_a.bus_state), 0);
        chk("t1_cmd_end", 32'(if_a.cmd[1]), WAIT);
        chk("t1_busy_res", 32'(if_a.busy), 1);
        tick(1);
        chk("t1_idle", 32'(if_a.busy), 0);

        // fixed priority
        do_reset();
        id_v[0] = 2'd1;
        id_v[1] = 2'd3;
        tick(2);
        chk("t2_clear0", 32'(if_a.cmd[0]), CLEAR);
        chk("t2_wait1",  32'(if_a.cmd[1]), WAIT);
        com_v[0] = COM_C;
        tick(1);
        chk("t2_bus0", 32'(if_a.bus_state), 3'b001);
        tick(3);
        chk("t2_nopre", 32'(if_a.cmd[0]), CLEAR);
        com_v[0] = END_C;
        id_v[0]  = 2'd0;
        tick(1);
        chk("t2_bus_end", 32'(if_a.bus_state), 0);
        tick(3);
        chk("t2_clear1", 32'(if_a.cmd[1]), CLEAR);
        chk("t2_wait0",  32'(if_a.cmd[0]), WAIT);
        com_v[1] = COM_C;
        tick(1);
        chk("t2_bus1", 32'(if_a.bus_state), 3'b111);
        com_v[1] = END_C;
        id_v[1]  = 2'd0;
        tick(2);
        chk("t2_idle", 32'(if_a.busy), 0);

        // round-robin: grant order 1,0,1
        do_reset();
        id_v[0] = 2'd1;
        id_v[1] = 2'd2;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_clear_%0d", i), 32'(if_b.cmd[order[i]]), CLEAR);
            chk($sformatf("t3_wait_%0d", i),  32'(if_b.cmd[1 - order[i]]), WAIT);
            com_v[order[i]] = COM_C;
            tick(1);
            chk($sformatf("t3_bus_%0d", i), 32'(if_b.bus_state), (order[i] == 1) ? 3'b110 : 3'b001);
            com_v[order[i]] = END_C;
            tick(4);
        end
        id_v = '0;
        tick(4);

        // pause / resume
        do_reset();
        id_v[1] = 2'd2;
        tick(2);
        chk("t4_clear1", 32'(if_a.cmd[1]), CLEAR);
        com_v[1] = COM_C;
        tick(1);
        chk("t4_bus1", 32'(if_a.bus_state), 3'b110);
        tick(19);
        id_v[0] = 2'd1;
        tick(1);
        chk("t4_stop_p", 32'(if_a.cmd[1]), STOP_P);
        chk("t4_bus_drain", 32'(if_a.bus_state), 3'b110);
        done_v[1] = 1'b1;
        com_v[1]  = END_C;
        tick(1);
        chk("t4_bus_rel", 32'(if_a.bus_state), 0);
        chk("t4_cmd1_rel", 32'(if_a.cmd[1]), WAIT);
        done_v[1] = 1'b0;
        tick(1);
        chk("t4_clear0", 32'(if_a.cmd[0]), CLEAR);
        com_v[0] = COM_C;
        tick(1);
        chk("t4_bus0", 32'(if_a.bus_state), 3'b001);
        tick(2);
        com_v[0] = END_C;
        id_v[0]  = 2'd0;
        tick(1);
        chk("t4_bus0_end", 32'(if_a.bus_state), 0);
        tick(2);
        chk("t4_resume_clear", 32'(if_a.cmd[1]), CLEAR);
        com_v[1] = COM_C;
        tick(1);
        chk("t4_resume_bus", 32'(if_a.bus_state), 3'b110);
        com_v[1] = END_C;
        id_v[1]  = 2'd0;
        tick(2);
        chk("t4_idle", 32'(if_a.busy), 0);

        // hard stop beyond THRESH
        do_reset();
        id_v[1] = 2'd2;
        tick(2);
        com_v[1] = COM_C;
        tick(1);
        chk("t5_bus1", 32'(if_c.bus_state), 3'b110);
        tick(11);
        id_v[0] = 2'd1;
        tick(1);
        chk("t5_stop_s", 32'(if_c.cmd[1]), STOP_S);
        done_v[1] = 1'b1;
        id_v[1]   = 2'd0;
        com_v[1]  = END_C;
        tick(1);
        chk("t5_bus_rel", 32'(if_c.bus_state), 0);
        done_v[1] = 1'b0;
        tick(1);
        chk("t5_clear0", 32'(if_c.cmd[0]), CLEAR);
        com_v[0] = COM_C;
        tick(1);
        chk("t5_bus0", 32'(if_c.bus_state), 3'b001);
        com_v[0] = END_C;
        id_v[0]  = 2'd0;
        tick(2);
        chk("t5_idle", 32'(if_c.busy), 0);
        tick(2);
        chk("t5_no_resume_busy", 32'(if_c.busy), 0);
        chk("t5_no_resume_cmd",  32'(if_c.cmd[1]), WAIT);

        // ACK watchdog
        do_reset();
        id_v[1]  = 2'd2;
        com_v[1] = WACK;
        tick(2);
        chk("t6_clear", 32'(if_d.cmd[1]), CLEAR);
        tick(15);
        chk("t6_no_tmo_yet", 32'(if_d.timeout_err), 0);
        tick(1);
        chk("t6_tmo", 32'(if_d.timeout_err), 1);
        chk("t6_tmo_bus", 32'(if_d.bus_state), 0);
        id_v[1]  = 2'd0;
        com_v[1] = END_C;
        tick(1);
        chk("t6_tmo_pulse", 32'(if_d.timeout_err), 0);
        chk("t6_idle", 32'(if_d.busy), 0);

        // async reset mid-COM
        id_v[1]  = 2'd2;
        com_v[1] = COM_C;
        tick(3);
        chk("t6_com_bus", 32'(if_d.bus_state), 3'b110);
        rstN = 1'b0;
        #2;
        chk("t6_rst_bus",  32'(if_d.bus_state), 0);
        chk("t6_rst_cmd",  32'(if_d.cmd), 0);
        chk("t6_rst_busy", 32'(if_d.busy), 0);
        id_v  = '0;
        com_v = '0;
        tick(1);
        rstN = 1'b1;
        tick(2);
        chk("t6_after_rst", 32'(if_d.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 time units");
        $fatal(1, "bench time limit");
    end
endmodule
